uart_char_tx: RTL and testbench
===============================

Name: uart_char_tx

Overview:
Serial character transmitter, the sending end of the board-to-board link that the receive-side bit-in-character counter terminates. Accepts a parallel byte, frames it as 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), 10 bits per character. It holds each bit for a programmable number of system clocks and signals completion with a one-cycle pulse. It sits between the game-logic message sequencer and the wireless transmitter module's serial input.

Parameters:
BIT_TICKS, 16, system clocks per serial bit; legal range 1..65535; tick counter is 16 bits wide.

Ports:
sys_clock  input  1  system clock; all state changes on rising edge.
reset_n  input  1  asynchronous, active-low reset.
tx_data  input  8  character to send; sampled only on an accepted load.
load  input  1  request to send tx_data; level-sampled each edge.
tx_busy  output  1  high while a frame is in progress.
tx_serial  output  1  registered serial line; idles high.
char_sent  output  1  one-cycle pulse when the stop bit completes.
bit_count  output  4  bits fully sent in the current frame (0..9); 0 when idle.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, tx_serial=1, tx_busy=0, char_sent=0, bit_count=0, tick counter=0, shift register=0. Reset asserted mid-frame abandons the frame immediately: line goes high with no char_sent. After release the block waits in IDLE for load.
- States: IDLE, START, DATA, STOP.
- IDLE: tx_serial=1. On an edge with load=1, latch tx_data into the shift register, go to START with tx_serial=0, tx_busy=1, tick=0. The first start-bit cycle is the cycle after the accepting edge.
- Tick counter: counts 0..BIT_TICKS-1 in START, DATA and STOP. At terminal count it resets to 0 and the bit advances: bit_count increments, and the shift register shifts right by one.
- START: after BIT_TICKS cycles go to DATA, with tx_serial = data bit 0.
- DATA: each bit is held exactly BIT_TICKS cycles. After the 8th data bit (bit_count reaches 9) go to STOP with tx_serial=1.
- STOP: after BIT_TICKS cycles go to IDLE. Terminal state is a full 10-bit frame (count 4'b1010 internally).
- Frame end, on the same edge: tx_busy=0, bit_count=0, and char_sent=1 for exactly one cycle.
- Frame length: tx_busy is high for exactly 10*BIT_TICKS cycles.
- Load handling:
  - load is ignored while tx_busy=1. There is no queuing, and tx_data changes mid-frame have no effect.
  - load held high during the char_sent cycle is accepted at the next edge (the state is IDLE). This gives back-to-back frames with exactly one idle-high cycle between stop and the next start.
  - load held continuously gives repeated frames, each separated by one idle cycle.
- BIT_TICKS=1: every bit lasts one cycle and a frame is 10 cycles. No special casing is allowed.
- Outputs are fully registered; there is no combinational path from load or tx_data to tx_serial.

Test Plan:
- Reset → hold reset_n=0 with load=1 → tx_serial=1, tx_busy=0, char_sent=0, bit_count=0 throughout. After release, no frame starts until a sampled load.
- Single frame, BIT_TICKS=4, tx_data=8'hA5, one-cycle load → tx_serial sequence 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. tx_busy high for 40 cycles. char_sent pulses once, on cycle 41 after the accepting edge. bit_count steps 0..9.
- Load while busy: send 8'h3C, then pulse load with tx_data=8'hFF at cycle 12 → line carries only 8'h3C framing. A single char_sent, and no second frame.
- Back-to-back, BIT_TICKS=4, load held high with 8'h01 then 8'h80 → two frames, exactly one idle-high cycle between the first stop bit and the second start bit, and two char_sent pulses 41 cycles apart.
- Reset mid-frame: drop reset_n during data bit 3 → tx_serial=1 and tx_busy=0 asynchronously, no char_sent. A new load of 8'h55 then produces a complete correct frame.
- BIT_TICKS=1, tx_data=8'h00 → serial 0,0,0,0,0,0,0,0,0,1 over 10 cycles, char_sent on cycle 11.

Source files
------------

// File: rtl/uart_char_tx.sv
// -----------------------------------------------------------------------------
// uart_char_tx
// Serial character transmitter. It frames one byte as a start bit (0), eight
// data bits LSB first and a stop bit (1), and holds each bit for BIT_TICKS
// system clocks. A one-cycle char_sent pulse marks the end of the stop bit.
//
// Ports
//   sys_clock  in   system clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   tx_data    in   [7:0] character to send, sampled only on an accepted load
//   load       in   send request, level-sampled, ignored while busy
//   tx_busy    out  high while a frame is in progress
//   tx_serial  out  registered serial line, idles high
//   char_sent  out  one-cycle pulse when the stop bit completes
//   bit_count  out  [3:0] bits fully sent in the current frame, 0 when idle
// -----------------------------------------------------------------------------
module uart_char_tx #(
  parameter int unsigned BIT_TICKS = 16  // system clocks per serial bit, 1..65535
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       load,
  output logic       tx_busy,
  output logic       tx_serial,
  output logic       char_sent,
  output logic [3:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [15:0] TICK_LAST     = 16'(BIT_TICKS - 1);
  // bit_count value reached when the last data bit finishes.
  localparam logic [3:0]  DATA_DONE_CNT = 4'd9;

  state_e      state_q,   state_d;
  logic [15:0] tick_q,    tick_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic        serial_q,  serial_d;
  logic        busy_q,    busy_d;
  logic        sent_q,    sent_d;

  logic        tick_done;
  logic [3:0]  bit_next;

  assign tick_done = (tick_q == TICK_LAST);
  assign bit_next  = bit_cnt_q + 4'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    sent_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d  = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = 4'd0;
        tick_d    = 16'd0;
        if (load) begin
          shift_d  = tx_data;
          state_d  = START;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START, DATA, STOP: begin
        if (!tick_done) begin
          tick_d = tick_q + 16'd1;
        end else begin
          // Bit boundary: restart the tick count, count the finished bit and
          // expose the next data bit at shift_q[0] for the following boundary.
          tick_d    = 16'd0;
          bit_cnt_d = bit_next;
          shift_d   = {1'b0, shift_q[7:1]};
          if (state_q == START) begin
            state_d  = DATA;
            serial_d = shift_q[0];
          end else if (state_q == DATA) begin
            if (bit_next == DATA_DONE_CNT) begin
              state_d  = STOP;
              serial_d = 1'b1;
            end else begin
              serial_d = shift_q[0];
            end
          end else begin
            // Stop bit done: the frame is complete at ten bits, so the count
            // returns straight to zero instead of showing 10.
            state_d   = IDLE;
            serial_d  = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
            sent_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= 16'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
    end
  end

  assign tx_busy   = busy_q;
  assign tx_serial = serial_q;
  assign char_sent = sent_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_char_tx
// Directed bench for uart_char_tx. One instance runs with BIT_TICKS=4, a second
// with BIT_TICKS=1. Expected line bits are pushed to a queue when a frame is
// requested and popped as the serial line presents each bit.
// -----------------------------------------------------------------------------
module tb_uart_char_tx;

  logic       clk;
  logic       rst_n;

  logic [7:0] data4;
  logic       load4;
  logic       busy4, ser4, sent4;
  logic [3:0] cnt4;

  logic [7:0] data1;
  logic       load1;
  logic       busy1, ser1, sent1;
  logic [3:0] cnt1;

  int         n_checks = 0;
  int         n_errors = 0;
  int unsigned cyc_no = 0;
  int unsigned sent_stamp = 0;
  int unsigned first_stamp = 0;

  logic       exp_q[$];
  logic       b1;

  uart_char_tx #(.BIT_TICKS(4)) dut4 (
    .sys_clock (clk),
    .reset_n   (rst_n),
    .tx_data   (data4),
    .load      (load4),
    .tx_busy   (busy4),
    .tx_serial (ser4),
    .char_sent (sent4),
    .bit_count (cnt4)
  );

  uart_char_tx #(.BIT_TICKS(1)) dut1 (
    .sys_clock (clk),
    .reset_n   (rst_n),
    .tx_data   (data1),
    .load      (load1),
    .tx_busy   (busy1),
    .tx_serial (ser1),
    .char_sent (sent1),
    .bit_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame: start, data LSB first, stop.
  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic idle4(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle busy4", busy4, 1'b0);
      check("idle ser4", ser4, 1'b1);
      check("idle sent4", sent4, 1'b0);
      check("idle cnt4", cnt4, 4'd0);
    end
  endtask

  // Follows a BIT_TICKS=4 frame whose accepting edge is the next posedge.
  // Cycle k (1..40) is the k-th cycle of the frame, cycle 41 the char_sent one.
  task automatic watch4(input bit keep_load, input int poke_k, input int stop_k);
    logic exp_bit;
    exp_bit = 1'b1;
    for (int k = 1; k <= stop_k; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        if ((k - 1) % 4 == 0) begin
          check("queue has bit", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) exp_bit = exp_q.pop_front();
        end
        check("frame busy4", busy4, 1'b1);
        check("frame ser4", ser4, exp_bit);
        check("frame cnt4", cnt4, 32'((k - 1) / 4));
        check("frame sent4", sent4, 1'b0);
      end else begin
        check("end busy4", busy4, 1'b0);
        check("end sent4 pulse", sent4, 1'b1);
        check("end cnt4", cnt4, 4'd0);
        check("end ser4", ser4, 1'b1);
        sent_stamp = cyc_no;
      end
      if (k == 1 && !keep_load) load4 = 1'b0;
      if (poke_k > 0 && k == poke_k) begin
        data4 = 8'hFF;
        load4 = 1'b1;
      end
      if (poke_k > 0 && k == poke_k + 1) load4 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load4 = 1'b1;
    data4 = 8'hA5;
    load1 = 1'b1;
    data1 = 8'h00;

    // Reset held with load high: outputs stay idle.
    repeat (3) begin
      @(negedge clk);
      check("rst ser4", ser4, 1'b1);
      check("rst busy4", busy4, 1'b0);
      check("rst sent4", sent4, 1'b0);
      check("rst cnt4", cnt4, 4'd0);
      check("rst ser1", ser1, 1'b1);
      check("rst busy1", busy1, 1'b0);
    end
    rst_n = 1'b1;
    load4 = 1'b0;
    load1 = 1'b0;
    idle4(5);

    // Single frame 8'hA5.
    push_frame(8'hA5);
    data4 = 8'hA5;
    load4 = 1'b1;
    watch4(1'b0, 0, 41);
    idle4(3);

    // Load while busy is ignored, no second frame follows.
    push_frame(8'h3C);
    data4 = 8'h3C;
    load4 = 1'b1;
    watch4(1'b0, 12, 41);
    idle4(45);
    check("no leftover bits", exp_q.size(), 0);

    // Back-to-back with load held: one idle-high cycle between frames.
    push_frame(8'h01);
    data4 = 8'h01;
    load4 = 1'b1;
    watch4(1'b1, 0, 41);
    first_stamp = sent_stamp;
    push_frame(8'h80);
    data4 = 8'h80;
    watch4(1'b0, 0, 41);
    check("char_sent spacing", sent_stamp - first_stamp, 41);
    idle4(2);

    // Reset during data bit 3 abandons the frame at once.
    push_frame(8'h96);
    data4 = 8'h96;
    load4 = 1'b1;
    watch4(1'b0, 0, 18);
    #2 rst_n = 1'b0;
    #1;
    check("async rst ser4", ser4, 1'b1);
    check("async rst busy4", busy4, 1'b0);
    check("async rst cnt4", cnt4, 4'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("held rst sent4", sent4, 1'b0);
      check("held rst ser4", ser4, 1'b1);
    end
    rst_n = 1'b1;
    idle4(3);
    push_frame(8'h55);
    data4 = 8'h55;
    load4 = 1'b1;
    watch4(1'b0, 0, 41);
    idle4(2);

    // BIT_TICKS=1, 8'h00: one cycle per bit.
    push_frame(8'h00);
    data1 = 8'h00;
    load1 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 10) begin
        check("bt1 queue has bit", exp_q.size() != 0, 1'b1);
        b1 = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
        check("bt1 ser1", ser1, b1);
        check("bt1 busy1", busy1, 1'b1);
        check("bt1 cnt1", cnt1, 32'(k - 1));
        check("bt1 sent1", sent1, 1'b0);
      end else begin
        check("bt1 end sent1", sent1, 1'b1);
        check("bt1 end busy1", busy1, 1'b0);
        check("bt1 end ser1", ser1, 1'b1);
      end
      if (k == 1) load1 = 1'b0;
    end
    @(negedge clk);
    check("bt1 sent1 one cycle", sent1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
